// File: rtl/ex_stage_mdu.sv
// Execute stage: ID/EX register, forwarding muxes, ALU and an iterative unsigned
// multiply/divide unit that owns the HI/LO registers and stalls the pipeline while busy.
module ex_stage_mdu #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FlushE,
  input  logic              StallE,
  input  logic [WIDTH-1:0]  RD1_in,
  input  logic [WIDTH-1:0]  RD2_in,
  input  logic [WIDTH-1:0]  SignImmD,
  input  logic [WIDTH-1:0]  ALUOutM,
  input  logic [WIDTH-1:0]  ResultW,
  input  logic              MemWriteD,
  input  logic              RegWriteD,
  input  logic              RegDstD,
  input  logic              ALUSrcD,
  input  logic              MemtoRegD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RdD,
  input  logic [3:0]        ALUControlD,
  input  logic [1:0]        MduOpD,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  output logic [WIDTH-1:0]  ALUOutE,
  output logic [WIDTH-1:0]  WriteDataE,
  output logic              MemWriteE,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic [REG_AW-1:0] WriteRegE,
  output logic [REG_AW-1:0] RsE,
  output logic [REG_AW-1:0] RtE,
  output logic              MduBusyE,
  output logic [WIDTH-1:0]  HiE,
  output logic [WIDTH-1:0]  LoE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef struct packed {
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  imm;
    logic              memWrite;
    logic              regWrite;
    logic              regDst;
    logic              aluSrc;
    logic              memtoReg;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [3:0]        aluCtrl;
    logic [1:0]        mduOp;
  } idex_t;

  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_DONE} mduState_t;

  idex_t            idex_q, idex_d;
  mduState_t        state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] acc_q, shf_q, opB_q, hi_q, lo_q;
  logic             isDiv_q;

  logic [WIDTH-1:0] srcA, srcB;
  logic             mduStart;
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic [WIDTH-1:0] accNext, shfNext;

  // Flush wins over stall so a squashed instruction never lingers in E.
  always_comb begin
    idex_d = idex_q;
    if (FlushE) begin
      idex_d = '0;
    end else if (!StallE) begin
      idex_d.rd1      = RD1_in;
      idex_d.rd2      = RD2_in;
      idex_d.imm      = SignImmD;
      idex_d.memWrite = MemWriteD;
      idex_d.regWrite = RegWriteD;
      idex_d.regDst   = RegDstD;
      idex_d.aluSrc   = ALUSrcD;
      idex_d.memtoReg = MemtoRegD;
      idex_d.rs       = RsD;
      idex_d.rt       = RtD;
      idex_d.rd       = RdD;
      idex_d.aluCtrl  = ALUControlD;
      idex_d.mduOp    = MduOpD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  always_comb begin
    case (ForwardAE)
      2'b00:   srcA = idex_q.rd1;
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUOutM;
      default: srcA = '0;
    endcase
    case (ForwardBE)
      2'b00:   WriteDataE = idex_q.rd2;
      2'b01:   WriteDataE = ResultW;
      2'b10:   WriteDataE = ALUOutM;
      default: WriteDataE = '0;
    endcase
    srcB = idex_q.aluSrc ? idex_q.imm : WriteDataE;
  end

  always_comb begin
    case (idex_q.aluCtrl)
      4'b0000: ALUOutE = srcA & srcB;
      4'b0001: ALUOutE = srcA | srcB;
      4'b0010: ALUOutE = srcA + srcB;
      4'b0110: ALUOutE = srcA - srcB;
      4'b0111: ALUOutE = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      4'b0011: ALUOutE = srcA ^ srcB;
      4'b0100: ALUOutE = ~(srcA | srcB);
      4'b1000: ALUOutE = hi_q;
      4'b1001: ALUOutE = lo_q;
      default: ALUOutE = '0;
    endcase
  end

  assign WriteRegE = idex_q.regDst ? idex_q.rd : idex_q.rt;
  assign MemWriteE = idex_q.memWrite;
  assign RegWriteE = idex_q.regWrite;
  assign MemtoRegE = idex_q.memtoReg;
  assign RsE       = idex_q.rs;
  assign RtE       = idex_q.rt;
  assign HiE       = hi_q;
  assign LoE       = lo_q;

  // Busy must rise in the very cycle the op reaches E so the hazard unit freezes it there.
  assign mduStart = (state_q == MDU_IDLE) && !FlushE &&
                    ((idex_q.mduOp == 2'b01) || (idex_q.mduOp == 2'b10));
  assign MduBusyE = mduStart || (state_q == MDU_RUN);

  // acc holds the running high product / partial remainder; shf holds multiplier / quotient bits.
  always_comb begin
    mulSum   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opB_q} : {(WIDTH+1){1'b0}});
    divShift = {acc_q, shf_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, opB_q};
    if (isDiv_q) begin
      if (!divDiff[WIDTH]) begin
        accNext = divDiff[WIDTH-1:0];
        shfNext = {shf_q[WIDTH-2:0], 1'b1};
      end else begin
        accNext = divShift[WIDTH-1:0];
        shfNext = {shf_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      accNext = mulSum[WIDTH:1];
      shfNext = {mulSum[0], shf_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      shf_q   <= '0;
      opB_q   <= '0;
      isDiv_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (mduStart) begin
            state_q <= MDU_RUN;
            count_q <= '0;
            acc_q   <= '0;
            shf_q   <= srcA;
            opB_q   <= WriteDataE;
            isDiv_q <= (idex_q.mduOp == 2'b10);
          end
        end
        MDU_RUN: begin
          if (FlushE) begin
            state_q <= MDU_IDLE;
          end else begin
            acc_q   <= accNext;
            shf_q   <= shfNext;
            count_q <= count_q + CW'(1);
            if (count_q == LAST_STEP) begin
              state_q <= MDU_DONE;
              hi_q    <= accNext;
              lo_q    <= shfNext;
            end
          end
        end
        MDU_DONE: begin
          // The finished op is still in E until the stall lifts; leaving early would restart it.
          if (!StallE) state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Scoreboard bench for ex_stage_mdu: a 32-bit instance for the ALU/forwarding/MDU paths
// and a 16-bit instance for the narrow multiply/divide and DONE-hold behaviour.
module tb_ex_stage_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, FlushE, tbStall, StallE;
  logic [31:0] rd1, rd2, imm, aluOutM, resultW;
  logic        memWriteD, regWriteD, regDstD, aluSrcD, memtoRegD;
  logic [4:0]  rsD, rtD, rdD;
  logic [3:0]  aluCtrlD;
  logic [1:0]  mduOpD, fwdA, fwdB;
  logic [31:0] ALUOutE, WriteDataE, HiE, LoE;
  logic        MemWriteE, RegWriteE, MemtoRegE, MduBusyE;
  logic [4:0]  WriteRegE, RsE, RtE;

  logic [15:0] s16Rd1, s16Rd2, s16AluOut, s16WriteData, s16Hi, s16Lo;
  logic [3:0]  s16Ctrl;
  logic [1:0]  s16MduOp;
  logic        s16Stall, s16StallE, s16Busy, s16MemWrite, s16RegWrite, s16MemtoReg;
  logic [4:0]  s16WriteReg, s16Rs, s16Rt;

  assign StallE    = MduBusyE | tbStall;
  assign s16StallE = s16Busy | s16Stall;

  ex_stage_mdu #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .StallE(StallE),
    .RD1_in(rd1), .RD2_in(rd2), .SignImmD(imm), .ALUOutM(aluOutM), .ResultW(resultW),
    .MemWriteD(memWriteD), .RegWriteD(regWriteD), .RegDstD(regDstD), .ALUSrcD(aluSrcD),
    .MemtoRegD(memtoRegD), .RsD(rsD), .RtD(rtD), .RdD(rdD), .ALUControlD(aluCtrlD),
    .MduOpD(mduOpD), .ForwardAE(fwdA), .ForwardBE(fwdB),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .RsE(RsE), .RtE(RtE),
    .MduBusyE(MduBusyE), .HiE(HiE), .LoE(LoE)
  );

  ex_stage_mdu #(.WIDTH(16), .REG_AW(5)) dut16 (
    .clk(clk), .rst(rst), .FlushE(1'b0), .StallE(s16StallE),
    .RD1_in(s16Rd1), .RD2_in(s16Rd2), .SignImmD(16'h0000), .ALUOutM(16'h0000), .ResultW(16'h0000),
    .MemWriteD(1'b0), .RegWriteD(1'b0), .RegDstD(1'b0), .ALUSrcD(1'b0),
    .MemtoRegD(1'b0), .RsD(5'd0), .RtD(5'd0), .RdD(5'd0), .ALUControlD(s16Ctrl),
    .MduOpD(s16MduOp), .ForwardAE(2'b00), .ForwardBE(2'b00),
    .ALUOutE(s16AluOut), .WriteDataE(s16WriteData), .MemWriteE(s16MemWrite), .RegWriteE(s16RegWrite),
    .MemtoRegE(s16MemtoReg), .WriteRegE(s16WriteReg), .RsE(s16Rs), .RtE(s16Rt),
    .MduBusyE(s16Busy), .HiE(s16Hi), .LoE(s16Lo)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } expEntry_t;

  expEntry_t expQ[$];
  int totalChecks = 0;
  int badChecks   = 0;
  int busyCnt     = 0;

  localparam int S_ALU = 0, S_WD = 1, S_HI = 2, S_LO = 3, S_BUSYCNT = 4, S_WREG = 5,
                 S_REGW = 9, S_MEMW = 10, S_MEMTOREG = 11, S_RS = 12, S_RT = 13, S_BUSY = 14,
                 S16_BUSY = 20, S16_HI = 21, S16_LO = 22, S16_WD = 23, S16_ALU = 24;

  function automatic logic [31:0] obsValue(input int sel);
    case (sel)
      S_ALU:      return ALUOutE;
      S_WD:       return WriteDataE;
      S_HI:       return HiE;
      S_LO:       return LoE;
      S_BUSYCNT:  return 32'(busyCnt);
      S_WREG:     return {27'd0, WriteRegE};
      S_REGW:     return {31'd0, RegWriteE};
      S_MEMW:     return {31'd0, MemWriteE};
      S_MEMTOREG: return {31'd0, MemtoRegE};
      S_RS:       return {27'd0, RsE};
      S_RT:       return {27'd0, RtE};
      S_BUSY:     return {31'd0, MduBusyE};
      S16_BUSY:   return {31'd0, s16Busy};
      S16_HI:     return {16'd0, s16Hi};
      S16_LO:     return {16'd0, s16Lo};
      S16_WD:     return {16'd0, s16WriteData};
      S16_ALU:    return {16'd0, s16AluOut};
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input string tag, input int sel, input logic [31:0] val);
    expEntry_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic drainScoreboard();
    expEntry_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.tag, obsValue(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] im, input logic src, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [1:0] mdu);
    aluCtrlD = ctrl;
    rd1      = a;
    rd2      = b;
    imm      = im;
    aluSrcD  = src;
    fwdA     = fa;
    fwdB     = fb;
    mduOpD   = mdu;
  endtask

  task automatic waitBusy32();
    busyCnt = 0;
    while (MduBusyE && busyCnt < 200) begin
      busyCnt++;
      tick();
    end
  endtask

  task automatic waitBusy16();
    busyCnt = 0;
    while (s16Busy && busyCnt < 200) begin
      busyCnt++;
      tick();
    end
  endtask

  task automatic runMdu32(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    applyStimulus(4'b0000, a, b, 32'd0, 1'b0, 2'b00, 2'b00, op);
    pushExp({tag, "_busy"}, S_BUSYCNT, 32'd33);
    pushExp({tag, "_hi"}, S_HI, expHi);
    pushExp({tag, "_lo"}, S_LO, expLo);
    tick();
    applyStimulus(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    waitBusy32();
    drainScoreboard();
  endtask

  task automatic runMdu16(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] expHi, input logic [15:0] expLo);
    s16Rd1 = a;
    s16Rd2 = b;
    s16MduOp = op;
    s16Ctrl = 4'b0000;
    pushExp({tag, "_busy"}, S_BUSYCNT, 32'd17);
    pushExp({tag, "_hi"}, S16_HI, {16'd0, expHi});
    pushExp({tag, "_lo"}, S16_LO, {16'd0, expLo});
    pushExp({tag, "_wd"}, S16_WD, {16'd0, b});
    tick();
    s16MduOp = 2'b00;
    s16Rd1 = 16'd0;
    s16Rd2 = 16'd0;
    waitBusy16();
    drainScoreboard();
  endtask

  logic [31:0] ra, rb;
  logic        doSub;

  initial begin
    rst = 1'b1; FlushE = 1'b0; tbStall = 1'b0;
    applyStimulus(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    aluOutM = 32'd0; resultW = 32'd0;
    memWriteD = 1'b0; regWriteD = 1'b0; regDstD = 1'b0; memtoRegD = 1'b0;
    rsD = 5'd0; rtD = 5'd0; rdD = 5'd0;
    s16Rd1 = 16'd0; s16Rd2 = 16'd0; s16Ctrl = 4'd0; s16MduOp = 2'd0; s16Stall = 1'b0;

    tick();
    tick();
    checkOutput("rst_alu", ALUOutE, 32'd0);
    checkOutput("rst_busy", {31'd0, MduBusyE}, 32'd0);
    checkOutput("rst_hi", HiE, 32'd0);
    checkOutput("rst_lo", LoE, 32'd0);
    checkOutput("rst_regw", {31'd0, RegWriteE}, 32'd0);
    rst = 1'b0;

    // ALU and forwarding
    applyStimulus(4'b0010, 32'd5, 32'd99, 32'd0, 1'b0, 2'b00, 2'b10, 2'b00);
    aluOutM = 32'd7; regWriteD = 1'b1; regDstD = 1'b1; rtD = 5'd3; rdD = 5'd9;
    pushExp("add", S_ALU, 32'd12);
    pushExp("add_wd", S_WD, 32'd7);
    pushExp("wreg_rd", S_WREG, 32'd9);
    pushExp("add_regw", S_REGW, 32'd1);
    tick();
    drainScoreboard();
    fwdA = 2'b11;
    pushExp("fwdA_zero", S_ALU, 32'd7);
    #1 drainScoreboard();
    fwdA = 2'b01; fwdB = 2'b00; resultW = 32'h100;
    pushExp("fwdA_resw", S_ALU, 32'h163);
    pushExp("fwdB_reg", S_WD, 32'd99);
    #1 drainScoreboard();
    fwdA = 2'b00; fwdB = 2'b01;
    pushExp("fwdB_resw", S_WD, 32'h100);
    pushExp("fwdB_resw_alu", S_ALU, 32'h105);
    #1 drainScoreboard();

    regDstD = 1'b0;
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    pushExp("slt", S_ALU, 32'd1);
    pushExp("wreg_rt", S_WREG, 32'd3);
    tick(); drainScoreboard();
    applyStimulus(4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    pushExp("slt_false", S_ALU, 32'd0);
    tick(); drainScoreboard();
    applyStimulus(4'b0110, 32'd3, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    pushExp("sub", S_ALU, 32'hFFFF_FFFE);
    tick(); drainScoreboard();
    applyStimulus(4'b0001, 32'h0F, 32'hAA, 32'h10, 1'b1, 2'b00, 2'b00, 2'b00);
    pushExp("or_imm", S_ALU, 32'h1F);
    pushExp("or_imm_wd", S_WD, 32'hAA);
    tick(); drainScoreboard();
    applyStimulus(4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    pushExp("xor", S_ALU, 32'h0000_FF00);
    tick(); drainScoreboard();
    applyStimulus(4'b0100, 32'hF0F0_0000, 32'h0000_F0F0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    pushExp("nor", S_ALU, 32'h0F0F_0F0F);
    tick(); drainScoreboard();
    applyStimulus(4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    pushExp("and", S_ALU, 32'h0F00_0F00);
    tick(); drainScoreboard();
    applyStimulus(4'b0101, 32'd5, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    pushExp("bad_code", S_ALU, 32'd0);
    tick(); drainScoreboard();

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      doSub = i[0];
      applyStimulus(doSub ? 4'b0110 : 4'b0010, ra, rb, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
      pushExp(doSub ? "rand_sub" : "rand_add", S_ALU, doSub ? ra - rb : ra + rb);
      tick(); drainScoreboard();
    end

    // Stall hold, then flush with stall both high
    applyStimulus(4'b0010, 32'd7, 32'd8, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    regWriteD = 1'b1; memWriteD = 1'b1; memtoRegD = 1'b1; rsD = 5'd4; rtD = 5'd6; rdD = 5'd11; regDstD = 1'b1;
    pushExp("load_alu", S_ALU, 32'd15);
    pushExp("load_rs", S_RS, 32'd4);
    pushExp("load_memw", S_MEMW, 32'd1);
    tick(); drainScoreboard();
    tbStall = 1'b1;
    applyStimulus(4'b0110, 32'd1, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    rsD = 5'd2;
    pushExp("stall_alu", S_ALU, 32'd15);
    pushExp("stall_rs", S_RS, 32'd4);
    pushExp("stall_wreg", S_WREG, 32'd11);
    tick(); drainScoreboard();
    FlushE = 1'b1;
    pushExp("flush_alu", S_ALU, 32'd0);
    pushExp("flush_wd", S_WD, 32'd0);
    pushExp("flush_regw", S_REGW, 32'd0);
    pushExp("flush_memw", S_MEMW, 32'd0);
    pushExp("flush_memtoreg", S_MEMTOREG, 32'd0);
    pushExp("flush_rs", S_RS, 32'd0);
    pushExp("flush_rt", S_RT, 32'd0);
    pushExp("flush_wreg", S_WREG, 32'd0);
    tick(); drainScoreboard();
    FlushE = 1'b0; tbStall = 1'b0;
    regWriteD = 1'b0; memWriteD = 1'b0; memtoRegD = 1'b0; regDstD = 1'b0;
    rsD = 5'd0; rtD = 5'd0; rdD = 5'd0;

    // MULTU followed by MFHI / MFLO
    applyStimulus(4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 2'b01);
    pushExp("multu_busy", S_BUSYCNT, 32'd33);
    pushExp("multu_hi", S_HI, 32'd1);
    pushExp("multu_lo", S_LO, 32'hFFFF_FFFE);
    tick();
    applyStimulus(4'b1000, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    waitBusy32();
    drainScoreboard();
    tick();
    pushExp("mfhi", S_ALU, 32'd1);
    pushExp("after_multu_busy", S_BUSY, 32'd0);
    drainScoreboard();
    applyStimulus(4'b1001, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    tick();
    pushExp("mflo", S_ALU, 32'hFFFF_FFFE);
    drainScoreboard();

    runMdu32("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    tick();
    runMdu32("divu0", 2'b10, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    tick();

    // Flush during RUN at count 10
    applyStimulus(4'b0000, 32'd3, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 2'b01);
    tick();
    applyStimulus(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    repeat (11) tick();
    pushExp("pre_flush_busy", S_BUSY, 32'd1);
    drainScoreboard();
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    pushExp("abort_busy", S_BUSY, 32'd0);
    pushExp("abort_hi", S_HI, 32'd9);
    pushExp("abort_lo", S_LO, 32'hFFFF_FFFF);
    drainScoreboard();
    tick();
    pushExp("abort_norestart", S_BUSY, 32'd0);
    drainScoreboard();

    // Asynchronous reset in the middle of a divide
    applyStimulus(4'b0000, 32'd100, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 2'b10);
    regWriteD = 1'b1; rtD = 5'd5;
    tick();
    applyStimulus(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    regWriteD = 1'b0; rtD = 5'd0;
    repeat (5) tick();
    pushExp("mid_div_busy", S_BUSY, 32'd1);
    pushExp("mid_div_regw", S_REGW, 32'd1);
    drainScoreboard();
    #2 rst = 1'b1;
    #1;
    pushExp("arst_busy", S_BUSY, 32'd0);
    pushExp("arst_hi", S_HI, 32'd0);
    pushExp("arst_lo", S_LO, 32'd0);
    pushExp("arst_alu", S_ALU, 32'd0);
    pushExp("arst_regw", S_REGW, 32'd0);
    pushExp("arst_rt", S_RT, 32'd0);
    drainScoreboard();
    tick();
    rst = 1'b0;

    // Narrow instance: multiply, hold in DONE, then divide and MFLO
    runMdu16("m16", 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
    s16Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pushExp("hold_busy", S16_BUSY, 32'd0);
      pushExp("hold_hi", S16_HI, 32'h0000_FFFE);
      drainScoreboard();
    end
    s16Stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pushExp("release_busy", S16_BUSY, 32'd0);
      drainScoreboard();
    end
    runMdu16("d16", 2'b10, 16'd1000, 16'd7, 16'd6, 16'd142);
    s16Ctrl = 4'b1001;
    tick();
    tick();
    pushExp("mflo16", S16_ALU, 32'd142);
    drainScoreboard();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
